// File: rtl/serial_subtractor_pkg.sv
// ============================================================================
// Module : serial_subtractor_pkg
// Brief  : State encodings and default width shared by the serial subtractor.
// Rev    : 1.0
// ============================================================================
`default_nettype none

package serial_subtractor_pkg;

  localparam int unsigned DEFAULT_WIDTH = 8;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE = 2'd0;
  localparam state_t ST_RUN  = 2'd1;
  localparam state_t ST_DONE = 2'd2;

endpackage

`default_nettype wire

// File: rtl/serial_subtractor_fullsub1bit.sv
// ============================================================================
// Module : fullsub1bit
// Brief  : One-bit full subtractor cell: d = a - b - bor with borrow out.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module fullsub1bit (
  input  logic a_i,
  input  logic b_i,
  input  logic bor_i,
  output logic d_o,
  output logic bor_o
);

  always_comb begin
    d_o   = a_i ^ b_i ^ bor_i;
    bor_o = (~a_i & b_i) | (~(a_i ^ b_i) & bor_i);
  end

endmodule

`default_nettype wire

// File: rtl/serial_subtractor.sv
// ============================================================================
// Module : serial_subtractor
// Brief  : Bit-serial two's-complement subtractor D = A - B, LSB first, with
//          start/busy/done handshake and registered borrow/overflow flags.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module serial_subtractor
  import serial_subtractor_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [WIDTH-1:0] d_o,
  output logic             borrow_o,
  output logic             ovf_o
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  state_t state_q, state_d;

  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-2:0] res_q, res_d;
  logic             bor_q, bor_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             a_msb_q, a_msb_d;
  logic             b_msb_q, b_msb_d;
  logic [WIDTH-1:0] dout_q, dout_d;
  logic             borrow_out_q, borrow_out_d;
  logic             ovf_q, ovf_d;

  logic             cell_d;
  logic             cell_bor;
  logic [WIDTH-1:0] res_shift;

  fullsub1bit u_cell (
    .a_i   (a_q[0]),
    .b_i   (b_q[0]),
    .bor_i (bor_q),
    .d_o   (cell_d),
    .bor_o (cell_bor)
  );

  // The newest bit enters at the MSB; after WIDTH shifts the full result is aligned.
  assign res_shift = {cell_d, res_q};

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (start_i) state_d = ST_RUN;
      ST_RUN:  if (cnt_q == CNT_LAST) state_d = ST_DONE;
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    busy_o   = (state_q != ST_IDLE);
    done_o   = (state_q == ST_DONE);
    d_o      = dout_q;
    borrow_o = borrow_out_q;
    ovf_o    = ovf_q;
  end

  always_comb begin
    a_d          = a_q;
    b_d          = b_q;
    res_d        = res_q;
    bor_d        = bor_q;
    cnt_d        = cnt_q;
    a_msb_d      = a_msb_q;
    b_msb_d      = b_msb_q;
    dout_d       = dout_q;
    borrow_out_d = borrow_out_q;
    ovf_d        = ovf_q;
    case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          a_d     = a_i;
          b_d     = b_i;
          res_d   = '0;
          bor_d   = 1'b0;
          cnt_d   = '0;
          a_msb_d = a_i[WIDTH-1];
          b_msb_d = b_i[WIDTH-1];
        end
      end
      ST_RUN: begin
        a_d   = a_q >> 1;
        b_d   = b_q >> 1;
        res_d = res_shift[WIDTH-1:1];
        bor_d = cell_bor;
        if (cnt_q == CNT_LAST) begin
          cnt_d        = '0;
          dout_d       = res_shift;
          borrow_out_d = cell_bor;
          ovf_d        = (a_msb_q ^ b_msb_q) & (cell_d ^ a_msb_q);
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      a_q          <= '0;
      b_q          <= '0;
      res_q        <= '0;
      bor_q        <= 1'b0;
      cnt_q        <= '0;
      a_msb_q      <= 1'b0;
      b_msb_q      <= 1'b0;
      dout_q       <= '0;
      borrow_out_q <= 1'b0;
      ovf_q        <= 1'b0;
    end else begin
      a_q          <= a_d;
      b_q          <= b_d;
      res_q        <= res_d;
      bor_q        <= bor_d;
      cnt_q        <= cnt_d;
      a_msb_q      <= a_msb_d;
      b_msb_q      <= b_msb_d;
      dout_q       <= dout_d;
      borrow_out_q <= borrow_out_d;
      ovf_q        <= ovf_d;
    end
  end

endmodule

`default_nettype wire
